// File: rtl/buffer_c_serializer.sv
// Result buffer: captures MMU result rows in parallel and streams them out serially in row-major order.
// Optional output clamping to the signed VAR_SIZE range is compiled in with `define SATURATE_EN.
module buffer_c_serializer #(
  parameter int VAR_SIZE = 8,
  parameter int ACC_SIZE = 32,
  parameter int MMU_SIZE = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ACC_SIZE*MMU_SIZE-1:0] C,
  input  logic                         stop,
  input  logic [1:0]                   cmd,
  input  logic [7:0]                   dim_x_in,
  input  logic [7:0]                   dim_y_in,
  output logic signed [ACC_SIZE-1:0]   D,
  output logic                         valid,
  output logic                         busy,
  output logic [7:0]                   dim_x_out,
  output logic [7:0]                   dim_y_out
);

  localparam int PW = $clog2(MMU_SIZE + 1);
  localparam logic [7:0] MAX_DIM = 8'(MMU_SIZE);
  localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'((64'sd1 <<< (VAR_SIZE - 1)) - 64'sd1);
  localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ~SAT_MAX;
`ifdef SATURATE_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SEND  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  state_t state, state_nxt;
  logic [PW-1:0] row_ptr, col_ptr;
  logic signed [ACC_SIZE-1:0] mem [MMU_SIZE][MMU_SIZE];

  logic issue_p0, wr_en, wr_zero, ptr_clr, row_inc, col_inc, col_wrap, dims_load, dims_zero;
  logic last_row, last_col, zero_dims;

  function automatic logic signed [ACC_SIZE-1:0] sat(input logic signed [ACC_SIZE-1:0] v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  function automatic logic [7:0] clamp_dim(input logic [7:0] d);
    return (d > MAX_DIM) ? MAX_DIM : d;
  endfunction

  assign last_row  = (8'(row_ptr) == dim_y_out - 8'd1);
  assign last_col  = (8'(col_ptr) == dim_x_out - 8'd1);
  assign zero_dims = (dim_x_out == 8'd0) || (dim_y_out == 8'd0);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    issue_p0  = 1'b0;
    wr_en     = 1'b0;
    wr_zero   = 1'b0;
    ptr_clr   = 1'b0;
    row_inc   = 1'b0;
    col_inc   = 1'b0;
    col_wrap  = 1'b0;
    dims_load = 1'b0;
    dims_zero = 1'b0;
    case (state)
      IDLE: begin
        if (cmd != 2'b00 && !stop) begin
          state_nxt = state_t'(cmd);
          ptr_clr   = 1'b1;
          dims_load = (cmd == 2'b01);
          dims_zero = (cmd == 2'b11);
        end
      end
      LOAD: begin
        if (cmd == 2'b11) begin
          state_nxt = CLEAR;
          ptr_clr   = 1'b1;
          dims_zero = 1'b1;
        end else if (zero_dims) begin
          state_nxt = IDLE;
        end else if (!stop) begin
          wr_en   = 1'b1;
          row_inc = 1'b1;
          if (last_row) state_nxt = IDLE;
        end
      end
      SEND: begin
        if (cmd == 2'b11) begin
          state_nxt = CLEAR;
          ptr_clr   = 1'b1;
          dims_zero = 1'b1;
        end else if (zero_dims) begin
          state_nxt = IDLE;
        end else if (!stop) begin
          issue_p0 = 1'b1;
          if (last_col) begin
            col_wrap = 1'b1;
            row_inc  = 1'b1;
            if (last_row) state_nxt = IDLE;
          end else begin
            col_inc = 1'b1;
          end
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        row_inc = 1'b1;
        if (8'(row_ptr) == MAX_DIM - 8'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_ptr   <= '0;
      col_ptr   <= '0;
      dim_x_out <= '0;
      dim_y_out <= '0;
    end else begin
      state <= state_nxt;
      if (ptr_clr) begin
        row_ptr <= '0;
        col_ptr <= '0;
      end else begin
        if (row_inc) row_ptr <= row_ptr + PW'(1);
        if (col_wrap) col_ptr <= '0;
        else if (col_inc) col_ptr <= col_ptr + PW'(1);
      end
      if (dims_load) begin
        dim_x_out <= clamp_dim(dim_x_in);
        dim_y_out <= clamp_dim(dim_y_in);
      end else if (dims_zero) begin
        dim_x_out <= '0;
        dim_y_out <= '0;
      end
    end
  end

  // Storage is intentionally left out of reset; CLEAR is the only way to zero it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < MMU_SIZE; i++)
        mem[row_ptr][i] <= wr_zero ? '0 : C[i*ACC_SIZE +: ACC_SIZE];
    end
  end

  // Output stage: one cycle after issue; D holds its last value when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= issue_p0;
      if (issue_p0) D <= SAT_ON ? sat(mem[row_ptr][col_ptr]) : mem[row_ptr][col_ptr];
    end
  end

endmodule

// File: tb/tb_buffer_c_serializer.sv
// Directed bench for buffer_c_serializer: a scoreboard queue holds the expected serial beats,
// and a negedge monitor pops and compares each valid output.
module tb_buffer_c_serializer;
  localparam int VAR = 8;
  localparam int ACC = 32;
  localparam int MMU = 10;
  localparam logic [1:0] C_NONE = 2'b00, C_LOAD = 2'b01, C_SEND = 2'b10, C_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ACC*MMU-1:0] C = '0;
  logic stop = 1'b0;
  logic [1:0] cmd = C_NONE;
  logic [7:0] dxi = '0, dyi = '0;
  logic signed [ACC-1:0] D;
  logic valid, busy;
  logic [7:0] dxo, dyo;

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int b0;
  int ex_x, ex_y;
  logic signed [63:0] q[$];
  logic signed [ACC-1:0] model [MMU][MMU];

  buffer_c_serializer #(.VAR_SIZE(VAR), .ACC_SIZE(ACC), .MMU_SIZE(MMU)) dut (
    .clk(clk), .rst_n(rst_n), .C(C), .stop(stop), .cmd(cmd),
    .dim_x_in(dxi), .dim_y_in(dyi), .D(D), .valid(valid), .busy(busy),
    .dim_x_out(dxo), .dim_y_out(dyo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [ACC-1:0] exp_out(input logic signed [ACC-1:0] v);
`ifdef SATURATE_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    logic signed [63:0] e;
    if (rst_n && valid) begin
      e = (q.size() > 0) ? q.pop_front() : 'x;
      beats++;
      chk("beat", D, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] c);
    cmd = c;
    tick();
    cmd = C_NONE;
  endtask

  task automatic load_row(input int r, input int base);
    for (int i = 0; i < MMU; i++) begin
      C[i*ACC +: ACC] = ACC'(base + i);
      model[r][i] = ACC'(base + i);
    end
    tick();
  endtask

  task automatic push_send();
    for (int r = 0; r < ex_y; r++)
      for (int c = 0; c < ex_x; c++)
        q.push_back(exp_out(model[r][c]));
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset values
    #3;
    chk("rst_D", D, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dimx", dxo, 0);
    chk("rst_dimy", dyo, 0);
    #19 rst_n = 1'b1;
    tick();

    // Test 1: 3x2 load and full send
    dxi = 8'd3; dyi = 8'd2;
    start(C_LOAD);
    load_row(0, 1);
    load_row(1, 4);
    chk("t1_load_idle", busy, 0);
    chk("t1_dimx", dxo, 3);
    chk("t1_dimy", dyo, 2);
    ex_x = 3; ex_y = 2;
    b0 = beats;
    push_send();
    start(C_SEND);
    repeat (5) tick();
    chk("t1_busy_before_last", busy, 1);
    tick();
    chk("t1_busy_after_last", busy, 0);
    tick();
    chk("t1_beats", beats - b0, 6);
    chk("t1_queue", q.size(), 0);

    // Test 2: stall for two cycles after the second beat
    b0 = beats;
    push_send();
    start(C_SEND);
    tick(); tick();
    stop = 1'b1;
    tick();
    chk("t2_stall1_valid", valid, 0);
    tick();
    chk("t2_stall2_valid", valid, 0);
    stop = 1'b0;
    wait_idle("t2_idle", 20);
    tick();
    chk("t2_beats", beats - b0, 6);
    chk("t2_queue", q.size(), 0);

    // Test 3: stall on the second row of a load
    start(C_LOAD);
    load_row(0, 7);
    stop = 1'b1;
    for (int i = 0; i < MMU; i++) C[i*ACC +: ACC] = ACC'(99);
    tick();
    chk("t3_stall_busy", busy, 1);
    stop = 1'b0;
    load_row(1, 10);
    chk("t3_load_idle", busy, 0);
    b0 = beats;
    push_send();
    start(C_SEND);
    wait_idle("t3_idle", 20);
    tick();
    chk("t3_beats", beats - b0, 6);

    // Test 4: oversized dims clamp to the array size
    dxi = 8'd12; dyi = 8'd12;
    start(C_LOAD);
    chk("t4_dimx", dxo, 10);
    chk("t4_dimy", dyo, 10);
    for (int r = 0; r < MMU; r++) load_row(r, r * 10 + 1);
    chk("t4_load_idle", busy, 0);
    ex_x = 10; ex_y = 10;
    b0 = beats;
    push_send();
    start(C_SEND);
    wait_idle("t4_idle", 150);
    tick();
    chk("t4_beats", beats - b0, 100);
    chk("t4_queue", q.size(), 0);

    // Test 5: CLEAR aborts a send
    b0 = beats;
    for (int c = 0; c < 3; c++) q.push_back(exp_out(model[0][c]));
    start(C_SEND);
    tick(); tick(); tick();
    cmd = C_CLEAR;
    tick();
    cmd = C_NONE;
    chk("t5_valid_low", valid, 0);
    chk("t5_busy", busy, 1);
    chk("t5_dimx", dxo, 0);
    chk("t5_dimy", dyo, 0);
    n = 1;
    while (busy && n < 30) begin
      tick();
      if (busy) n++;
    end
    chk("t5_clear_len", n, 10);
    ex_x = 0; ex_y = 0;
    start(C_SEND);
    tick();
    chk("t5_zero_send_idle", busy, 0);
    tick(); tick();
    chk("t5_beats", beats - b0, 3);
    chk("t5_queue", q.size(), 0);

    // Test 6: output formatting of large and negative values
    dxi = 8'd3; dyi = 8'd1;
    start(C_LOAD);
    C = '0;
    C[0*ACC +: ACC] = ACC'(300);
    C[1*ACC +: ACC] = ACC'(-1000);
    C[2*ACC +: ACC] = ACC'(5);
    model[0][0] = 300; model[0][1] = -1000; model[0][2] = 5;
    tick();
    chk("t6_load_idle", busy, 0);
    ex_x = 3; ex_y = 1;
    b0 = beats;
    push_send();
    start(C_SEND);
    wait_idle("t6_idle", 20);
    tick();
    chk("t6_beats", beats - b0, 3);
    chk("t6_last_D", D, exp_out(ACC'(5)));

    // Test 7: asynchronous reset in the middle of a load
    dxi = 8'd3; dyi = 8'd2;
    start(C_LOAD);
    load_row(0, 50);
    chk("t7_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_async_D", D, 0);
    chk("t7_async_valid", valid, 0);
    chk("t7_async_busy", busy, 0);
    chk("t7_async_dimx", dxo, 0);
    chk("t7_async_dimy", dyo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t7_post_busy", busy, 0);
    chk("t7_post_valid", valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/buffer_c_serializer.md
Name: buffer_c_serializer

Overview:
Result-side counterpart of the operand buffers. It captures result rows arriving in parallel from the MMU, one full row per cycle, into a single MMU_SIZE x MMU_SIZE local store. On command it streams the stored matrix out serially, one element per cycle, in row-major order. It sits between the MMU output and the host/readback path and uses the same 2-bit command set and stop-stall semantics as the operand buffers.

Parameters:
VAR_SIZE, 8, operand element width; saturation target width when SATURATE_EN is compiled in
ACC_SIZE, 32, result element width, signed
MMU_SIZE, 10, array dimension; maximum rows/columns stored

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
C  in  ACC_SIZE*MMU_SIZE  signed result row from MMU; element i at bits [(i+1)*ACC_SIZE-1 : i*ACC_SIZE]
stop  in  1  stall; freezes pointers and suppresses writes/output beats
cmd  in  2  00 NONE, 01 LOAD, 10 SEND, 11 CLEAR
dim_x_in  in  8  columns per row, sampled on LOAD accept
dim_y_in  in  8  row count, sampled on LOAD accept
D  out  ACC_SIZE  serial output element, signed
valid  out  1  D holds a valid element this cycle
busy  out  1  high whenever state != IDLE
dim_x_out  out  8  latched column count
dim_y_out  out  8  latched row count

Behaviour:
- Reset: asynchronous, active-low. State=IDLE; row_ptr, col_ptr, D, valid, dim_x_out and dim_y_out all 0. Storage array is not reset; CLEAR is the only way to zero it.
- States: IDLE, LOAD, SEND, CLEAR. Encodings match cmd.
- IDLE:
  - Command is accepted only when cmd != NONE and stop=0.
  - Pointers reset to 0 on accept.
  - LOAD accept latches dims. Each dim is clamped to MMU_SIZE if larger.
- LOAD:
  - Each cycle with stop=0 writes C into storage row row_ptr, columns 0..MMU_SIZE-1, then row_ptr++.
  - After row dim_y-1 is written, next state is IDLE.
  - With stop=1: no write and row_ptr holds.
- SEND:
  - Each cycle with stop=0 reads element [row_ptr][col_ptr] and registers it into D with valid=1 on the next cycle (1-cycle latency).
  - col_ptr wraps at dim_x-1, and row_ptr++ on wrap.
  - After element [dim_y-1][dim_x-1] is issued, next state is IDLE.
  - Exactly dim_x*dim_y beats are produced, with no skips or duplicates across stalls.
  - With stop=1: pointers hold and valid=0 on the following cycle. D holds its last value.
- CLEAR:
  - Zeros one storage row per cycle for MMU_SIZE cycles, then returns to IDLE.
  - dim_x_out and dim_y_out are set to 0 on entry.
  - stop is ignored in CLEAR.
- cmd=CLEAR in LOAD or SEND aborts the current operation and enters CLEAR next cycle, regardless of stop. Any valid beat already registered still appears for that one cycle.
- Other commands received outside IDLE are ignored.
- Zero dimension: a LOAD with dim_x_in=0 or dim_y_in=0 latches the zero dims and returns to IDLE next cycle with no writes. A SEND with dim_x_out=0 or dim_y_out=0 returns to IDLE next cycle, and valid never asserts.
- valid is 0 in every state except the cycle following an issuing SEND cycle.

Optional Feature:
SATURATE_EN
- Defined: each output element is clamped to the signed VAR_SIZE range [-2^(VAR_SIZE-1), 2^(VAR_SIZE-1)-1] and sign-extended to ACC_SIZE on D. Clamping happens at the output register, so latency is unchanged.
- Undefined: D carries the raw ACC_SIZE value unchanged.

Test Plan:
1. Reset; LOAD dims x=3, y=2 with row0 C={..,3,2,1}, row1 C={..,6,5,4}; then SEND -> 6 valid beats D=1,2,3,4,5,6; busy falls the cycle after the last issue.
2. SEND of the 3x2 matrix with stop=1 for 2 cycles after the 2nd beat -> valid=0 for exactly 2 cycles; the sequence stays 1..6 with no gaps or duplicates.
3. LOAD with stop=1 on the 2nd row cycle -> row written once, on the first stop=0 cycle; subsequent SEND shows the correct data.
4. LOAD dims 12x12 -> dim_x_out=dim_y_out=10; full SEND gives 100 beats.
5. CLEAR issued mid-SEND -> valid low within 1 cycle, busy high for 10 cycles, dims read 0; a following SEND produces zero beats.
6. With SATURATE_EN: stored 300 -> D=127, -1000 -> D=-128, 5 -> D=5. Without it: D=300, -1000, 5.
7. rst_n pulsed low mid-LOAD -> D, valid, busy and dims go to 0 immediately, before any clk edge; state is IDLE after release.
